rand_sample_src: RTL and testbench

Synthesizable stimulus source that drives the `circuit` sample interface (`en` strobe plus 32-bit signed sample `r`) from hardware instead of a bench. On `start` it emits NSAMP pseudo-random samples in the range −2047..+2047, one `en` pulse every two cycles. Each sample equals a signed 32-bit LFSR word reduced modulo 2048 with the sign kept, matching the distribution of the bench stimulus. It sits directly in front of `circuit` on FPGA/on-chip test builds, and `done` flags the end of the burst.

---
 rtl/rand_src_pkg.sv | 30 +++
 rtl/lfsr32_galois.sv | 27 ++
 rtl/rand_sample_src.sv | 97 +++++++++
 tb/tb_rand_sample_src.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rand_src_pkg.sv
// Shared definitions for the hardware random-sample source.
//   state_t         : burst sequencer states
//   LFSR_TAPS       : Galois feedback mask for x^32+x^22+x^2+x+1
//   RANGE_BITS      : magnitude bits kept by the signed-modulo reduction
//   reduce_sample() : maps a 32-bit LFSR word to a sample in -2047..+2047
package rand_src_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam int          RANGE_BITS = 11;

  // Treat the word as signed and take its magnitude modulo 2^RANGE_BITS,
  // then restore the sign. The magnitude of -2^31 has zero low bits, so
  // that word maps to 0.
  function automatic logic signed [RANGE_BITS:0] reduce_sample(input logic [31:0] v);
    logic [31:0]           mag;
    logic [RANGE_BITS-1:0] m;
    mag = v[31] ? (~v + 32'd1) : v;
    m   = mag[RANGE_BITS-1:0];
    if (v[31]) return -signed'({1'b0, m});
    return signed'({1'b0, m});
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR.
//   clk   : clock
//   rst   : asynchronous active-low reset, loads SEED
//   en    : advance one step on the next rising edge
//   state : current LFSR word
module lfsr32_galois
  import rand_src_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_07FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] state
);

  // NOTE: clocked state is always written with <=, so every flop samples
  // the pre-edge values and process ordering cannot change the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEED;
    end else if (en) begin
      state <= state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
    end
  end

endmodule

// File: rtl/rand_sample_src.sv
// Hardware stimulus source for the circuit sample interface. On start it
// emits NSAMP pseudo-random samples in -2047..+2047, one en pulse every
// two cycles (stretched by hold), then pulses done.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   start : begin a burst (only looked at while idle)
//   hold  : stretch the gap between samples while high
//   en    : one-cycle strobe per sample
//   r     : signed sample, valid with en, held otherwise
//   idx   : 1-based number of the sample currently/last on r
//   busy  : burst in progress
//   done  : one-cycle pulse after the last sample
module rand_sample_src
  import rand_src_pkg::*;
#(
  parameter int          W     = 32,
  parameter int          NSAMP = 100,
  parameter logic [31:0] SEED  = 32'h0000_07FF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hold,
  output logic                en,
  output logic signed [W-1:0] r,
  output logic [7:0]          idx,
  output logic                busy,
  output logic                done
);

  localparam logic [7:0] LAST_IDX = 8'(NSAMP);

  state_t      state;
  state_t      state_nx;
  logic        issue_nx;
  logic [31:0] lfsr_q;

  // The LFSR steps on the same edge that captures its current word into r,
  // so each sample consumes one value and the next burst continues on.
  lfsr32_galois #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (issue_nx),
    .state (lfsr_q)
  );

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   state_nx = GAP;
      // The final gap ignores hold so completion is never stalled.
      GAP: begin
        if (idx == LAST_IDX) state_nx = DONE;
        else if (!hold)      state_nx = ISSUE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign issue_nx = (state_nx == ISSUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Outputs are decoded from the next state and registered, so they line
  // up with the state they describe and have no input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en   <= 1'b0;
      r    <= '0;
      idx  <= 8'd0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      en   <= issue_nx;
      busy <= (state_nx == ISSUE) || (state_nx == GAP);
      done <= (state_nx == DONE);
      if (issue_nx) begin
        r   <= W'(reduce_sample(lfsr_q));
        // Leaving IDLE clears the count, so the first sample is number 1.
        idx <= (state == IDLE) ? 8'd1 : idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rand_sample_src.sv
// Self-checking bench for rand_sample_src. Four instances cover the seeds
// and burst lengths of interest; a high-level model (arithmetic LFSR rule
// plus integer modulo reduction) predicts every sample and its timing.
module tb_rand_sample_src;

  localparam logic [31:0] M_TAPS = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start_v [4];
  logic               hold_v  [4];
  logic               en_v    [4];
  logic signed [31:0] r_v     [4];
  logic [7:0]         idx_v   [4];
  logic               busy_v  [4];
  logic               done_v  [4];

  logic [31:0] seeds [4];
  logic [31:0] mlfsr [4];

  int checks = 0;
  int errors = 0;

  rand_sample_src #(.W(32), .NSAMP(100), .SEED(32'h0000_07FF)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .hold(hold_v[0]), .en(en_v[0]),
    .r(r_v[0]), .idx(idx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  rand_sample_src #(.W(32), .NSAMP(1), .SEED(32'h0000_07FF)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .hold(hold_v[1]), .en(en_v[1]),
    .r(r_v[1]), .idx(idx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  rand_sample_src #(.W(32), .NSAMP(4), .SEED(32'hFFFF_F801)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .hold(hold_v[2]), .en(en_v[2]),
    .r(r_v[2]), .idx(idx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  rand_sample_src #(.W(32), .NSAMP(3), .SEED(32'h8000_0000)) dut3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .hold(hold_v[3]), .en(en_v[3]),
    .r(r_v[3]), .idx(idx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] x);
    if (x % 2 == 1) return (x / 2) ^ M_TAPS;
    return x / 2;
  endfunction

  function automatic longint model_reduce(input logic [31:0] x);
    longint v;
    v = longint'(signed'(x));
    if (v >= 0) return v % 2048;
    return -((-v) % 2048);
  endfunction

  // One burst on instance d of length n. hold is raised for hold_len cycles
  // in the gap after sample hold_after (0 = never). spam pulses start at
  // random while the burst runs. Returns the DUT's first sample and the
  // cycle (relative to the start edge) at which done was seen.
  task automatic run_burst(input int d, input int n, input int hold_after,
                           input int hold_len, input bit spam,
                           output longint first_r, output int done_seen);
    int     t[$];
    longint exp_r[$];
    int     tcur;
    int     done_at;
    int     j;
    bit     is_en;
    longint last_r;
    tcur = 1;
    for (int s = 1; s <= n; s++) begin
      t.push_back(tcur);
      exp_r.push_back(model_reduce(mlfsr[d]));
      mlfsr[d] = model_next(mlfsr[d]);
      tcur += 2 + ((s == hold_after && s < n) ? hold_len : 0);
    end
    done_at   = t[n-1] + 2;
    first_r   = 99999;
    done_seen = -1;
    last_r    = 0;
    j         = 0;
    @(negedge clk);
    start_v[d] = 1'b1;
    for (int c = 1; c <= done_at + 1; c++) begin
      @(negedge clk);
      is_en = (j < n) && (c == t[j]);
      check($sformatf("d%0d c%0d en", d, c), en_v[d], is_en);
      check($sformatf("d%0d c%0d busy", d, c), busy_v[d], c <= t[n-1] + 1);
      check($sformatf("d%0d c%0d done", d, c), done_v[d], c == done_at);
      if (done_v[d] && done_seen < 0) done_seen = c;
      if (is_en) begin
        if (j == 0) first_r = r_v[d];
        check($sformatf("d%0d c%0d r", d, c), r_v[d], exp_r[j]);
        check($sformatf("d%0d c%0d idx", d, c), idx_v[d], j + 1);
        check($sformatf("d%0d c%0d range", d, c), (r_v[d] >= -2047 && r_v[d] <= 2047), 1);
        last_r = exp_r[j];
        j++;
      end else if (j > 0) begin
        check($sformatf("d%0d c%0d r_held", d, c), r_v[d], last_r);
      end
      start_v[d] = spam && (c < done_at) && ($urandom_range(3) == 0);
      hold_v[d]  = (hold_after >= 1) && (hold_after <= n) &&
                   (c >= t[hold_after-1] + 1) && (c <= t[hold_after-1] + hold_len);
    end
    start_v[d] = 1'b0;
    hold_v[d]  = 1'b0;
    check($sformatf("d%0d idx_kept", d), idx_v[d], n);
  endtask

  typedef struct {
    int     d;
    int     n;
    int     hold_after;
    int     hold_len;
    longint exp_first_r;
    int     exp_done;
  } vec_t;

  initial begin
    vec_t   tbl [5];
    longint fr;
    int     dn;
    longint exp_a;
    longint exp_b;

    seeds[0] = 32'h0000_07FF;
    seeds[1] = 32'h0000_07FF;
    seeds[2] = 32'hFFFF_F801;
    seeds[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      mlfsr[i]   = seeds[i];
      start_v[i] = 1'b0;
      hold_v[i]  = 1'b0;
    end

    tbl[0] = '{d: 1, n: 1, hold_after: 0, hold_len: 0, exp_first_r: 2047,  exp_done: 3};
    tbl[1] = '{d: 2, n: 4, hold_after: 0, hold_len: 0, exp_first_r: -2047, exp_done: 9};
    tbl[2] = '{d: 3, n: 3, hold_after: 1, hold_len: 5, exp_first_r: 0,     exp_done: 12};
    tbl[3] = '{d: 3, n: 3, hold_after: 3, hold_len: 4, exp_first_r: 0,     exp_done: 7};
    tbl[4] = '{d: 1, n: 1, hold_after: 0, hold_len: 0, exp_first_r: -1028, exp_done: 3};

    // Power-on reset.
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d%0d reset en", i), en_v[i], 0);
      check($sformatf("d%0d reset r", i), r_v[i], 0);
      check($sformatf("d%0d reset idx", i), idx_v[i], 0);
      check($sformatf("d%0d reset busy", i), busy_v[i], 0);
      check($sformatf("d%0d reset done", i), done_v[i], 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed bursts: seeds, pacing, backpressure, final-gap hold.
    for (int k = 0; k < 5; k++) begin
      run_burst(tbl[k].d, tbl[k].n, tbl[k].hold_after, tbl[k].hold_len, 1'b0, fr, dn);
      check($sformatf("tbl%0d first_r", k), fr, tbl[k].exp_first_r);
      check($sformatf("tbl%0d done_cycle", k), dn, tbl[k].exp_done);
      repeat (2) @(negedge clk);
    end

    // start held high: next burst's en comes two cycles after done.
    exp_a = model_reduce(mlfsr[1]);
    mlfsr[1] = model_next(mlfsr[1]);
    exp_b = model_reduce(mlfsr[1]);
    mlfsr[1] = model_next(mlfsr[1]);
    @(negedge clk);
    start_v[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("b2b c%0d en", c), en_v[1], (c == 1) || (c == 5));
      check($sformatf("b2b c%0d done", c), done_v[1], (c == 3) || (c == 7));
      if (c == 1) check("b2b r1", r_v[1], exp_a);
      if (c == 5) begin
        check("b2b r2", r_v[1], exp_b);
        start_v[1] = 1'b0;
      end
    end

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset busy", busy_v[0], 1);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d%0d async en", i), en_v[i], 0);
      check($sformatf("d%0d async r", i), r_v[i], 0);
      check($sformatf("d%0d async idx", i), idx_v[i], 0);
      check($sformatf("d%0d async busy", i), busy_v[i], 0);
      check($sformatf("d%0d async done", i), done_v[i], 0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) mlfsr[i] = seeds[i];
    repeat (3) @(negedge clk);
    check("post_reset done", done_v[0], 0);
    check("post_reset busy", busy_v[0], 0);
    run_burst(1, 1, 0, 0, 1'b0, fr, dn);
    check("post_reset first_r", fr, 2047);
    check("post_reset done_cycle", dn, 3);

    // Random sweep: full-length bursts with random hold and start spam.
    for (int b = 0; b < 2; b++) begin
      run_burst(0, 100, int'($urandom_range(100, 1)), int'($urandom_range(6, 0)), 1'b1, fr, dn);
      repeat (3) @(negedge clk);
      check($sformatf("sweep%0d idle en", b), en_v[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
